// File: rtl/mult_pkg.sv
// Shared constants for the iterative HI/LO multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_CALC = 2'd1;
  localparam logic [1:0] MS_DONE = 2'd2;

  localparam int MULT_WIDTH = 32;

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper accumulator half (carry kept), then shift the whole accumulator right.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mplier_lsb,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] upper;

  always_comb begin
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier_lsb) begin
      upper = upper + {1'b0, mcand};
    end
    // The carry bit becomes the new MSB once the accumulator shifts right.
    acc_next = (2*WIDTH)'({upper, acc[WIDTH-1:0]} >> 1);
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative MULT/MULTU unit with HI/LO registers and MTHI/MTLO write port.
// Signed operands are multiplied as magnitudes and the product negated at the end.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   mcand_reg, mplier_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               neg_reg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] result;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_reg),
    .mcand      (mcand_reg),
    .mplier_lsb (mplier_reg[0]),
    .acc_next   (acc_next)
  );

  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign result = neg_reg ? -acc_next : acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MS_IDLE: if (start) state_next = MS_CALC;
      MS_CALC: if (count_reg == LAST) state_next = MS_DONE;
      MS_DONE: state_next = start ? MS_CALC : MS_IDLE;
      default: state_next = MS_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == MS_CALC);
    done = (state_reg == MS_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (state_reg == MS_CALC) begin
      acc_reg    <= acc_next;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + 1'b1;
      if (count_reg == LAST) begin
        {hi_reg, lo_reg} <= result;
      end
    end else begin
      // MTHI/MTLO land now; a product started this edge overwrites them at done.
      if (hi_we) hi_reg <= wdata;
      if (lo_we) lo_reg <= wdata;
      if (start) begin
        acc_reg    <= '0;
        count_reg  <= '0;
        mcand_reg  <= abs_a;
        mplier_reg <= abs_b;
        neg_reg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier for MIPS MULT/MULTU, with HI/LO result registers and MTHI/MTLO write port.
- Sits in EX alongside the ALU; its hi/lo outputs feed the result-select multiplexer ahead of the EX/MEM register.
- Start/busy/done handshake lets the hazard unit stall issue while a product is computing.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin multiply using a, b, is_signed (sampled at the edge)
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU
- a  in  WIDTH  multiplicand (rs)
- b  in  WIDTH  multiplier (rt)
- hi_we  in  1  MTHI: write wdata to hi
- lo_we  in  1  MTLO: write wdata to lo
- wdata  in  WIDTH  data for MTHI/MTLO
- busy  out  1  high while iterating; stall request
- done  out  1  one-cycle pulse; hi/lo hold the new product in this cycle
- hi  out  WIDTH  upper product half / HI register
- lo  out  WIDTH  lower product half / LO register

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, DONE.
  - IDLE: start=1 -> CALC.
  - CALC: runs for WIDTH cycles, then -> DONE.
  - DONE: lasts one cycle, then -> IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back ops).
- Latency:
  - start sampled at the end of cycle 0.
  - busy=1 in cycles 1..WIDTH.
  - done=1 and new hi/lo visible in cycle WIDTH+1.
  - busy=0 outside CALC; done=0 outside DONE.
- Operand capture at start:
  - Signed: latch magnitudes |a|, |b| as WIDTH-bit unsigned, plus neg = a[WIDTH-1]^b[WIDTH-1]. The most-negative value's magnitude (2^(WIDTH-1)) fits unsigned.
  - Unsigned: latch a, b as-is, neg=0.
- Iteration, one per CALC cycle, radix-2:
  - If multiplier LSB=1, add multiplicand into the upper half of the 2*WIDTH accumulator, using a WIDTH+1-bit carry.
  - Then shift accumulator and multiplier right by one.
- On the edge entering DONE:
  - {hi,lo} <= neg ? two's-complement of accumulator (2*WIDTH bits) : accumulator.
  - Result is exact mod 2^(2*WIDTH).
- start while in CALC: ignored; the operation in progress is unaffected.
- hi_we/lo_we:
  - Honoured only when state != CALC, and not on the edge entering DONE; ignored while busy.
  - hi_we and lo_we together in the same cycle both write wdata.
  - If start and a write coincide in IDLE/DONE, the write takes effect and the later product overwrites it.
- hi/lo hold their value otherwise. They are never modified during CALC, so stale values stay readable until done.
- rst during CALC or DONE: return to IDLE next edge with all reset values; the partial product is discarded and done is never pulsed.
- Zero operands still take the full WIDTH cycles; no early termination.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants MS_IDLE=2'd0, MS_CALC=2'd1, MS_DONE=2'd2
  - MULT_WIDTH=32
- Sub-module mult_step (combinational): one shift-add iteration.
  - Inputs: accumulator, multiplicand, multiplier LSB.
  - Output: next accumulator.
  - Lets the verifier unit-test the step exhaustively at small WIDTH.
- Control FSM, counter, sign handling and HI/LO registers stay in mult_unit.

Test Plan:
- Reset then unsigned 6*7 (a=6, b=7, is_signed=0, start 1 cycle) -> busy high for cycles 1..32; done in cycle 33 with hi=0x00000000, lo=0x0000002A.
- Signed -3*5 (a=0xFFFFFFFD, b=5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Boundary cases:
  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
  - MULT 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Handshake:
  - start=1 again at cycle 10 of an op with a=2, b=2 -> ignored; first result unchanged and done pulses exactly once.
  - start in the DONE cycle -> second op's done lands 33 cycles later.
- MTHI/MTLO: hi_we with wdata=0x1234 while idle -> hi=0x1234 next cycle; lo_we during CALC -> ignored; lo keeps its prior value until done.
- rst asserted at cycle 15 of an op -> next cycle busy=0, hi=lo=0, state IDLE; no done pulse; a following op 4*4 gives lo=0x10.
